// File: rtl/gpio_arb_pkg.sv
// Shared types and constants for the two-requester GPIO port arbiter.
package gpio_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    localparam logic [1:0] ADDR_GPI1 = 2'b00;
    localparam logic [1:0] ADDR_GPI2 = 2'b01;
    localparam logic [1:0] ADDR_GPO1 = 2'b10;
    localparam logic [1:0] ADDR_GPO2 = 2'b11;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes to ptr_i.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] sel_o
);

    always_comb begin
        sel_o = req_i;
        if (req_i == 2'b11) begin
            sel_o = ptr_i ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/gpio_arbiter.sv
// Shares the GPIO register port between two requesters; each access runs
// grant/latch -> issue -> respond, and every output towards gpio_top is registered.
module gpio_arbiter
    import gpio_arb_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] a0,
    input  logic [WIDTH-1:0]  wd0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] a1,
    input  logic [WIDTH-1:0]  wd1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [WIDTH-1:0]  rd_out,
    output logic [ADDR_W-1:0] A,
    output logic              WE,
    output logic [WIDTH-1:0]  WD,
    input  logic [WIDTH-1:0]  RD
);

    state_e            state_q, state_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic              owner_q, owner_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        done_q, done_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic              we_q, we_d;
    logic [WIDTH-1:0]  wd_q, wd_d;
    logic [WIDTH-1:0]  rd_q, rd_d;
    logic [1:0]        sel;

    rr_arb2 u_rr_arb2 (
        .req_i (state_q == IDLE ? {req1, req0} : 2'b00),
        .ptr_i (rr_ptr_q),
        .sel_o (sel)
    );

    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        gnt_d    = gnt_q;
        done_d   = 2'b00;
        a_d      = a_q;
        we_d     = 1'b0;
        wd_d     = wd_q;
        rd_d     = rd_q;

        unique case (state_q)
            IDLE: begin
                if (sel != 2'b00) begin
                    owner_d = sel[1];
                    gnt_d   = sel;
                    a_d     = sel[1] ? a1  : a0;
                    we_d    = sel[1] ? we1 : we0;
                    wd_d    = sel[1] ? wd1 : wd0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // RD here still reflects the pre-write register contents.
                rd_d            = RD;
                done_d[owner_q] = 1'b1;
                state_d         = RESP;
            end
            RESP: begin
                rr_ptr_d = ~owner_q;
                gnt_d    = 2'b00;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            rr_ptr_q <= 1'b0;
            owner_q  <= 1'b0;
            gnt_q    <= 2'b00;
            done_q   <= 2'b00;
            a_q      <= '0;
            we_q     <= 1'b0;
            wd_q     <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            a_q      <= a_d;
            we_q     <= we_d;
            wd_q     <= wd_d;
            rd_q     <= rd_d;
        end
    end

    assign gnt0   = gnt_q[0];
    assign gnt1   = gnt_q[1];
    assign done0  = done_q[0];
    assign done1  = done_q[1];
    assign A      = a_q;
    assign WE     = we_q;
    assign WD     = wd_q;
    assign rd_out = rd_q;

endmodule

// File: tb/tb_gpio_arbiter.sv
// Bench for gpio_arbiter with a small gpio_top stand-in and a transaction-level model.
module tb_gpio_arbiter;
    import gpio_arb_pkg::*;

    logic        CLK, RST;
    logic        req0, we0, req1, we1;
    logic [1:0]  a0, a1, A;
    logic [31:0] wd0, wd1, WD, RD, rd_out;
    logic        gnt0, gnt1, done0, done1, WE;

    logic [31:0] gpi1, gpi2, gpo1_q, gpo2_q;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] model_gpo [2];
    logic        pref;
    logic [31:0] last_rd;

    gpio_arbiter #(.WIDTH(32), .ADDR_W(2)) dut (
        .CLK(CLK), .RST(RST),
        .req0(req0), .we0(we0), .a0(a0), .wd0(wd0),
        .req1(req1), .we1(we1), .a1(a1), .wd1(wd1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rd_out(rd_out), .A(A), .WE(WE), .WD(WD), .RD(RD)
    );

    // gpio_top stand-in: two input ports, two output registers, combinational read mux.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            gpo1_q <= '0;
            gpo2_q <= '0;
        end else if (WE) begin
            if (A == ADDR_GPO1) gpo1_q <= WD;
            if (A == ADDR_GPO2) gpo2_q <= WD;
        end
    end

    always_comb begin
        case (A)
            ADDR_GPI1: RD = gpi1;
            ADDR_GPI2: RD = gpi2;
            ADDR_GPO1: RD = gpo1_q;
            default:   RD = gpo2_q;
        endcase
    end

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return gpi1;
            2'd1:    return gpi2;
            2'd2:    return model_gpo[0];
            default: return model_gpo[1];
        endcase
    endfunction

    task automatic model_reset();
        model_gpo[0] = '0;
        model_gpo[1] = '0;
        pref         = 1'b0;
        last_rd      = '0;
    endtask

    // Called at the negedge of an IDLE cycle with at least one request driven.
    task automatic access(input bit hold, input bit disturb);
        logic        w;
        logic [1:0]  oh;
        logic [1:0]  ea;
        logic        ewe;
        logic [31:0] ewd, erd;
        w   = (req0 && req1) ? pref : req1;
        oh  = w ? 2'b10 : 2'b01;
        ea  = w ? a1 : a0;
        ewe = w ? we1 : we0;
        ewd = w ? wd1 : wd0;
        erd = model_read(ea);

        chk("idle_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        chk("idle_we", {31'd0, WE}, 32'd0);

        @(posedge CLK); @(negedge CLK);
        chk("issue_gnt", {30'd0, gnt1, gnt0}, {30'd0, oh});
        chk("issue_we", {31'd0, WE}, {31'd0, ewe});
        chk("issue_a", {30'd0, A}, {30'd0, ea});
        chk("issue_wd", WD, ewd);
        chk("issue_done", {30'd0, done1, done0}, 32'd0);
        if (disturb) begin
            if (w) req1 = 1'b0; else req0 = 1'b0;
            we0 = 1'($urandom_range(0, 1)); we1 = 1'($urandom_range(0, 1));
            a0  = 2'($urandom_range(0, 3)); a1  = 2'($urandom_range(0, 3));
            wd0 = $urandom;                 wd1 = $urandom;
        end

        @(posedge CLK); @(negedge CLK);
        chk("resp_done", {30'd0, done1, done0}, {30'd0, oh});
        chk("resp_gnt", {30'd0, gnt1, gnt0}, {30'd0, oh});
        chk("resp_we", {31'd0, WE}, 32'd0);
        chk("resp_a", {30'd0, A}, {30'd0, ea});
        chk("resp_wd", WD, ewd);
        chk("resp_rd", rd_out, erd);
        if (ewe && ea[1]) model_gpo[ea[0]] = ewd;
        chk("gpo1", gpo1_q, model_gpo[0]);
        chk("gpo2", gpo2_q, model_gpo[1]);
        pref    = ~w;
        last_rd = erd;
        if (!hold) begin
            if (w) req1 = 1'b0; else req0 = 1'b0;
        end

        @(posedge CLK); @(negedge CLK);
        chk("after_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        chk("after_done", {30'd0, done1, done0}, 32'd0);
        chk("after_rd", rd_out, last_rd);
    endtask

    initial begin
        RST = 1'b1;
        req0 = 0; we0 = 0; a0 = 0; wd0 = 0;
        req1 = 0; we1 = 0; a1 = 0; wd1 = 0;
        gpi1 = 0; gpi2 = 0;
        model_reset();

        #3;
        chk("rst_ctl", {27'd0, gnt1, gnt0, done1, done0, WE}, 32'd0);
        chk("rst_a", {30'd0, A}, 32'd0);
        chk("rst_wd", WD, 32'd0);
        chk("rst_rd", rd_out, 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Write gpo1 from requester 0.
        req0 = 1; we0 = 1; a0 = ADDR_GPO1; wd0 = 32'hA5A5_0001;
        access(0, 0);
        chk("t1_gpo1", gpo1_q, 32'hA5A5_0001);

        // Read gpi1 from requester 1.
        gpi1 = 32'h1234_5678;
        req1 = 1; we1 = 0; a1 = ADDR_GPI1;
        access(0, 0);
        chk("t2_rd", rd_out, 32'h1234_5678);

        // Both requesting and held: alternation 0,1,0,1.
        req0 = 1; we0 = 0; a0 = ADDR_GPO1;
        req1 = 1; we1 = 0; a1 = ADDR_GPI1;
        for (int i = 0; i < 4; i++) begin
            chk("t3_pref", {31'd0, pref}, i % 2);
            access(1, 0);
        end
        req0 = 0; req1 = 0;

        // Write gpo2 then read it back.
        req0 = 1; we0 = 1; a0 = ADDR_GPO2; wd0 = 32'd5;
        access(0, 0);
        req0 = 1; we0 = 0; a0 = ADDR_GPO2;
        access(0, 0);
        chk("t4_rd", rd_out, 32'd5);

        // Reset in the middle of a write's issue cycle.
        req0 = 1; we0 = 1; a0 = ADDR_GPO2; wd0 = 32'hFFFF_FFFF;
        @(posedge CLK); #2;
        chk("t5_we_before", {31'd0, WE}, 32'd1);
        RST = 1'b1;
        #1;
        chk("t5_ctl", {27'd0, gnt1, gnt0, done1, done0, WE}, 32'd0);
        chk("t5_a", {30'd0, A}, 32'd0);
        chk("t5_wd", WD, 32'd0);
        chk("t5_rd", rd_out, 32'd0);
        req0 = 0;
        #1 RST = 1'b0;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            chk("t5_done", {30'd0, done1, done0}, 32'd0);
            chk("t5_gpo2", gpo2_q, 32'd0);
        end

        // Request dropped and inputs scrambled during issue.
        req0 = 1; we0 = 1; a0 = ADDR_GPO1; wd0 = 32'hCAFE_0006;
        access(0, 1);

        // Randomised traffic.
        for (int i = 0; i < 60; i++) begin
            logic [1:0] r;
            r    = 2'($urandom_range(0, 3));
            gpi1 = $urandom; gpi2 = $urandom;
            req0 = r[0]; req1 = r[1];
            we0  = 1'($urandom_range(0, 1)); we1 = 1'($urandom_range(0, 1));
            a0   = 2'($urandom_range(0, 3)); a1  = 2'($urandom_range(0, 3));
            wd0  = $urandom;                 wd1 = $urandom;
            if (r == 2'b00) begin
                @(posedge CLK); @(negedge CLK);
                chk("rnd_idle", {27'd0, gnt1, gnt0, done1, done0, WE}, 32'd0);
                chk("rnd_idle_rd", rd_out, last_rd);
            end else begin
                access(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
